// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshakes.
// Whole-pipeline stall on output backpressure; bubbles are carried, not collapsed.
module ks_adder_pipe #(
  parameter int WIDTH     = 16,
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF
);
  localparam int L   = $clog2(WIDTH);
  localparam int LAT = 2 + (L - 1) / REG_EVERY;

  logic w_stall, w_en;
  assign w_stall  = out_valid & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = w_en;

  logic [LAT-1:0] r_vld_pipe;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_vld_pipe <= '0;
    else if (w_en) r_vld_pipe <= {r_vld_pipe[LAT-2:0], in_valid};
  end
  assign out_valid = r_vld_pipe[LAT-1];

  logic [WIDTH-1:0] r_a, r_b;
  logic             r_c0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_c0 <= 1'b0;
    end else if (w_en) begin
      r_a  <= A;
      r_b  <= SUB ? ~B : B;
      r_c0 <= SUB | CIN;
    end
  end

  // After level k only bits >= 2^k still need P, so each level's P vector
  // is trimmed to [WIDTH-1:2^k]; the last level produces G only.
  for (genvar k = 0; k <= L; k++) begin : g_lvl
    logic [WIDTH-1:0] w_g, w_po;
    logic             w_c0;

    if (k == 0) begin : g_base
      assign w_po = r_a ^ r_b;
      assign w_c0 = r_c0;
      assign w_g  = {r_a[WIDTH-1:1] & r_b[WIDTH-1:1],
                     (r_a[0] & r_b[0]) | (w_po[0] & r_c0)};
    end else begin : g_pre
      localparam int D = 1 << (k - 1);
      logic [WIDTH-1:0] w_gn;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i < D) begin : g_pass
          assign w_gn[i] = g_lvl[k-1].w_g[i];
        end else begin : g_cell
          assign w_gn[i] = g_lvl[k-1].w_g[i] |
                           (g_lvl[k-1].g_hasp.w_p[i] & g_lvl[k-1].w_g[i-D]);
        end
      end
      if ((k % REG_EVERY == 0) && (k < L)) begin : g_reg
        logic [WIDTH-1:0] r_g, r_po;
        logic             r_gc0;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_g   <= '0;
            r_po  <= '0;
            r_gc0 <= 1'b0;
          end else if (w_en) begin
            r_g   <= w_gn;
            r_po  <= g_lvl[k-1].w_po;
            r_gc0 <= g_lvl[k-1].w_c0;
          end
        end
        assign w_g  = r_g;
        assign w_po = r_po;
        assign w_c0 = r_gc0;
      end else begin : g_thru
        assign w_g  = w_gn;
        assign w_po = g_lvl[k-1].w_po;
        assign w_c0 = g_lvl[k-1].w_c0;
      end
    end

    if (k < L) begin : g_hasp
      localparam int PLO = 1 << k;
      logic [WIDTH-1:PLO] w_p;
      if (k == 0) begin : g_src
        assign w_p = w_po[WIDTH-1:1];
      end else begin : g_blk
        localparam int D = 1 << (k - 1);
        logic [WIDTH-1:PLO] w_pn;
        for (genvar i = PLO; i < WIDTH; i++) begin : g_bit
          assign w_pn[i] = g_lvl[k-1].g_hasp.w_p[i] & g_lvl[k-1].g_hasp.w_p[i-D];
        end
        if (k % REG_EVERY == 0) begin : g_reg
          logic [WIDTH-1:PLO] r_p;
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)    r_p <= '0;
            else if (w_en) r_p <= w_pn;
          end
          assign w_p = r_p;
        end else begin : g_thru
          assign w_p = w_pn;
        end
      end
    end
  end

  logic [WIDTH-1:0] w_gp, w_carry;
  assign w_gp    = g_lvl[L].w_g;
  assign w_carry = {w_gp[WIDTH-2:0], g_lvl[L].w_c0};

  logic [WIDTH-1:0] r_s;
  logic             r_cout, r_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_en) begin
      r_s    <= g_lvl[L].w_po ^ w_carry;
      r_cout <= w_gp[WIDTH-1];
      r_ovf  <= w_gp[WIDTH-1] ^ w_gp[WIDTH-2];
    end
  end
  assign S    = r_s;
  assign COUT = r_cout;
  assign OVF  = r_ovf;
endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe: default instance for directed/handshake steps plus
// a width/REG_EVERY sweep; each instance owns a scoreboard queue.
module tb_ks_adder_pipe;
  localparam int NCFG = 9;
  localparam int CW [NCFG] = '{16, 8, 8, 13, 13, 32, 32, 64, 64};
  localparam int CR [NCFG] = '{ 2, 1, 3,  1,  4,  1,  5,  1,  6};

  logic clk = 1'b0;
  logic rst_n, in_valid, cin, sub, or0;
  logic [63:0] a64, b64;
  logic [NCFG-1:0] ir, ov, co, of, ordy, w_empty;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign ordy = {{(NCFG-1){1'b1}}, or0};

  function automatic logic [65:0] model(input int w, input logic [63:0] a, b,
                                        input logic ci, su);
    logic [63:0] m, bb, s;
    logic [64:0] sum;
    logic c0, c, v;
    m   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    bb  = (su ? ~b : b) & m;
    c0  = su ? 1'b1 : ci;
    sum = {1'b0, a & m} + {1'b0, bb} + {64'd0, c0};
    s   = sum[63:0] & m;
    c   = sum[w];
    v   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {v, c, s};
  endfunction

  for (genvar j = 0; j < NCFG; j++) begin : g_dut
    localparam int W   = CW[j];
    localparam int R   = CR[j];
    localparam int L   = $clog2(W);
    localparam int LAT = 2 + (L - 1) / R;
    logic [W-1:0] s;
    logic [65:0]  q_exp [$];
    int           q_acc [$];
    int           q_st  [$];
    int           pend = 0;
    int           nst  = 0;
    bit           seen = 0;
    logic [65:0]  e;

    ks_adder_pipe #(.WIDTH(W), .REG_EVERY(R)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[j]),
      .A(a64[W-1:0]), .B(b64[W-1:0]), .CIN(cin), .SUB(sub),
      .out_valid(ov[j]), .out_ready(ordy[j]), .S(s), .COUT(co[j]), .OVF(of[j])
    );
    assign w_empty[j] = (pend == 0);

    always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_exp.delete(); q_acc.delete(); q_st.delete();
        pend = 0; seen = 0;
      end else begin
        if (ov[j] && q_exp.size() == 0) begin
          checks++;
          assert (ov[j] === 1'b0) else begin
            errors++;
            $error("FAIL spurious_out[%0d] out_valid=%b required 0", j, ov[j]);
          end
        end else if (ov[j]) begin
          e = q_exp[0];
          checks++;
          assert ({of[j], co[j], s} === {e[65:64], e[W-1:0]}) else begin
            errors++;
            $error("FAIL result[%0d] observed ovf,cout,s=%0h required %0h",
                   j, {of[j], co[j], s}, {e[65:64], e[W-1:0]});
          end
          if (!seen && q_st[0] == nst) begin
            checks++;
            assert (cyc - q_acc[0] === LAT - 1) else begin
              errors++;
              $error("FAIL latency[%0d] observed=%0d required=%0d",
                     j, cyc - q_acc[0] + 1, LAT);
            end
          end
          seen = 1;
          if (ordy[j]) begin
            void'(q_exp.pop_front()); void'(q_acc.pop_front()); void'(q_st.pop_front());
            pend--; seen = 0;
          end else begin
            nst++;
          end
        end
        if (in_valid && ir[j]) begin
          q_exp.push_back(model(W, a64, b64, cin, sub));
          q_acc.push_back(cyc + 1);
          q_st.push_back(nst);
          pend++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a, b, input logic ci, su);
    in_valid = 1'b1; a64 = a; b64 = b; cin = ci; sub = su;
  endtask

  // One beat on the default instance, checked against literal expectations.
  task automatic single(input string tag, input logic [15:0] a, b, input logic ci, su,
                        input logic [15:0] es, input logic ec, eo);
    int t0;
    bit got;
    @(posedge clk); #1 drive({48'd0, a}, {48'd0, b}, ci, su);
    @(negedge clk);
    check({tag, " in_ready"}, ir[0], 1);
    t0 = cyc;
    @(posedge clk); #1 in_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (ov[0]) got = 1;
    end
    check({tag, " out_valid_seen"}, got, 1);
    if (got) begin
      check({tag, " latency"}, cyc - t0, 3);
      check({tag, " S"}, g_dut[0].s, es);
      check({tag, " COUT"}, co[0], ec);
      check({tag, " OVF"}, of[0], eo);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sa [8];
    logic [15:0] sb [8];
    logic        sc [8];
    logic        ss [8];
    int          idx;
    bit          acc;

    rst_n = 1'b0; in_valid = 1'b0; a64 = '0; b64 = '0; cin = 1'b0; sub = 1'b0; or0 = 1'b1;
    repeat (2) @(negedge clk);
    check("reset out_valid", ov[0], 0);
    check("reset S", g_dut[0].s, 0);
    check("reset COUT", co[0], 0);
    check("reset OVF", of[0], 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", ir[0], 1);

    single("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    single("carry_chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    single("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    single("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Streaming with a 4-cycle out_ready drop mid-stream.
    for (int n = 0; n < 8; n++) begin
      sa[n] = 16'($urandom); sb[n] = 16'($urandom);
      sc[n] = 1'($urandom_range(0, 1)); ss[n] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    @(posedge clk); #1 drive({48'd0, sa[0]}, {48'd0, sb[0]}, sc[0], ss[0]);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      acc = in_valid && ir[0];
      if (ov[0] && !or0) check("stall in_ready", ir[0], 0);
      @(posedge clk); #1;
      if (acc) idx++;
      or0 = !(c >= 3 && c < 7);
      if (idx < 8) drive({48'd0, sa[idx]}, {48'd0, sb[idx]}, sc[idx], ss[idx]);
      else         in_valid = 1'b0;
    end
    check("stream accepted", idx, 8);
    @(negedge clk);
    check("stream drained", w_empty[0], 1);

    // Asynchronous reset with beats in flight.
    @(posedge clk); #1 drive(64'h0111, 64'h0222, 1'b0, 1'b0);
    @(posedge clk); #1 drive(64'h0333, 64'h0444, 1'b0, 1'b0);
    @(posedge clk); #1 drive(64'h0555, 64'h0666, 1'b0, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("pre-reset out_valid", ov[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", ov[0], 0);
    check("async reset S", g_dut[0].s, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no stale beat", ov[0], 0);
    end
    single("post_reset", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Parameter sweep: every instance accepts every beat (out_ready held high).
    @(posedge clk); #1 or0 = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      drive((n % 97 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom},
            (n % 89 == 0) ? 64'h0 : {$urandom, $urandom},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("sweep drained", w_empty, {NCFG{1'b1}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ks_adder_pipe.md
Name: ks_adder_pipe

Overview:
- Parametrised, pipelined Kogge-Stone adder/subtractor. Successor to the fixed 16-bit combinational prefix adder.
- Adds configurable width, carry-in, a subtract mode, carry-out and signed overflow outputs.
- Pipeline registers are inserted at a configurable prefix-level spacing.
- Valid/ready handshakes on both sides with full-pipeline stall on backpressure. Sits between operand-select logic and the result writeback path of the datapath.

Parameters:
- WIDTH, 16, operand width in bits; legal range 2..64.
- REG_EVERY, 2, number of prefix levels between pipeline registers; legal range 1..clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- CIN  input  1  carry-in (ignored when SUB=1)
- SUB  input  1  1 = compute A-B, 0 = A+B+CIN
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- S  output  WIDTH  sum/difference
- COUT  output  1  carry-out of MSB
- OVF  output  1  two's-complement signed overflow

Behaviour:
- One clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset (rst_n=0, asynchronous): all stage valid bits clear. out_valid=0, S=0, COUT=0, OVF=0. in_ready goes to 1 once reset is released.
- Datapath:
  - Stage 0 registers A, B' and c0 on accept. For SUB=1, B' = ~B and c0 = 1. For SUB=0, B' = B and c0 = CIN.
  - Then P = A^B', G = A&B'. Carry-in is folded in as G[0] = A0&B'0 | (A0^B'0)&c0.
  - L = clog2(WIDTH) Kogge-Stone prefix levels. Level k combines bit i with bit i-2^(k-1):
    - black cell where both P and G are needed;
    - gray cell where only G is needed (i-2^(k-1) < 2^(k-1));
    - pass-through when i < 2^(k-1).
  - A pipeline register follows prefix level k whenever k mod REG_EVERY == 0 and k < L. Registered signals: G, P and the original P vector.
- Output register:
  - S[0] = P[0]^c0.
  - S[i] = P[i]^Gprefix[i-1].
  - COUT = Gprefix[WIDTH-1].
  - OVF = carry into MSB XOR COUT.
- Latency: LAT = 2 + floor((L-1)/REG_EVERY) cycles from accept (in_valid&in_ready edge) to out_valid. Defaults (16, 2): LAT=3. REG_EVERY=1: LAT=5. REG_EVERY=L: LAT=2.
- Throughput: one beat per cycle when out_ready=1.
- Handshake:
  - Accept on the rising edge where in_valid&in_ready. Transfer out on the edge where out_valid&out_ready.
  - stall = out_valid & ~out_ready. While stall=1:
    - all pipeline registers, including valid bits, hold;
    - in_ready=0;
    - S, COUT and OVF are held stable.
  - in_ready = ~stall (combinational from out_ready).
  - Bubbles (invalid stages) are not collapsed. Data registers in invalid stages may load don't-care values, but out_valid must stay 0 for them.
  - Downstream must not see out_valid drop without a transfer.
- Simultaneous accept and output transfer in the same cycle is legal. The pipeline advances one stage.
- Width rules:
  - Arithmetic is modulo 2^WIDTH.
  - For SUB=1, COUT=1 means no borrow (A >= B unsigned).
  - Non-power-of-two WIDTH: prefix levels still number clog2(WIDTH). Out-of-range partner indices are pass-through.
- Reset mid-operation: all in-flight beats are discarded immediately and out_valid falls asynchronously. After release, the first output appears LAT cycles after the first new accept.

Test Plan:
- Defaults, out_ready=1, single beat A=0x1234, B=0x4321, CIN=0, SUB=0 -> S=0x5555, COUT=0, OVF=0, out_valid exactly 3 cycles after accept.
- Full-length carry: A=0xFFFF, B=0x0000, CIN=1 -> S=0x0000, COUT=1, OVF=0. Then A=0x7FFF, B=0x0001, CIN=0 -> S=0x8000, COUT=0, OVF=1.
- Subtract: A=0x0005, B=0x0007, SUB=1, CIN=1 (ignored) -> S=0xFFFE, COUT=0, OVF=0. Then A=0x8000, B=0x0001, SUB=1 -> S=0x7FFF, COUT=1, OVF=1.
- Streaming plus backpressure: 8 back-to-back random beats; out_ready low for 4 cycles mid-stream -> in_ready=0 during the stall, S held constant, no beat lost or duplicated, results in order and matching a reference model.
- Async reset: assert rst_n=0 between edges with 2 beats in flight -> out_valid=0 and S=0 immediately. After release, no stale beat emerges and the next beat has LAT=3.
- Parameter sweep: WIDTH in {8, 13, 32, 64} × REG_EVERY in {1, L}, 1000 random operand/mode beats each -> results match the reference model, and latency equals the LAT formula (e.g. WIDTH=32, REG_EVERY=1 -> LAT=6).
